// File: rtl/reg_file_multimode_pkg.sv
// rtl/reg_file_multimode_pkg.sv - shared widths and read-mode encoding for the decode-stage register file
package reg_file_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 8;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_ONE_OP = 2'd1;
  localparam logic [1:0] MODE_SWAP   = 2'd2;

  // A store needs its operands swapped even if the decoder also flagged one-operand.
  function automatic logic [1:0] read_mode(input logic mem_write, input logic one_operand);
    if (mem_write) begin
      return MODE_SWAP;
    end
    if (one_operand) begin
      return MODE_ONE_OP;
    end
    return MODE_NORMAL;
  endfunction

endpackage

// File: rtl/reg_file_multimode_if.sv
// rtl/reg_file_multimode_if.sv - control, address, write and read-data bundle of the register file
interface reg_file_multimode_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int BUF_DEPTH = 2
);

  logic                        stall;
  logic                        flush;
  logic                        one_operand;
  logic                        mem_write;
  logic [ADDR_W-1:0]           read_addr1;
  logic [ADDR_W-1:0]           read_addr2;
  logic                        reg_write;
  logic [ADDR_W-1:0]           write_addr;
  logic [DATA_W-1:0]           write_data;
  logic [DATA_W-1:0]           read_data1;
  logic [DATA_W-1:0]           read_data2;
  logic [BUF_DEPTH*DATA_W-1:0] read_data2_buf;

  modport master (
    output stall, flush, one_operand, mem_write,
    output read_addr1, read_addr2,
    output reg_write, write_addr, write_data,
    input  read_data1, read_data2, read_data2_buf
  );

  modport slave (
    input  stall, flush, one_operand, mem_write,
    input  read_addr1, read_addr2,
    input  reg_write, write_addr, write_data,
    output read_data1, read_data2, read_data2_buf
  );

endinterface

// File: rtl/reg_file_multimode_delay_line.sv
// rtl/reg_file_multimode_delay_line.sv - clearable shift register; slice k holds d delayed k+1 enabled edges
module reg_file_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       d,
  output logic [DEPTH*DATA_W-1:0] q_flat
);

  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [DATA_W-1:0] stage_d [DEPTH];

  // Clear wins over hold so a flush during a stall still empties the pipe.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] = '0;
      end
    end else if (en) begin
      stage_d[0] = d;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign q_flat[k*DATA_W +: DATA_W] = stage_q[k];
  end

endmodule

// File: rtl/reg_file_multimode.sv
// rtl/reg_file_multimode.sv - decode-stage register file with bypassed registered reads and operand-2 delay line
module reg_file_multimode
  import reg_file_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int BUF_DEPTH  = 2,
  parameter int ZERO_REG   = 0,
  parameter int INIT_INDEX = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_file_multimode_if.slave   bus
);

  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] op1, op2;
  logic              write_ok;

  function automatic logic addr_dead(input logic [ADDR_W-1:0] a);
    return (int'(a) >= NUM_REGS) || ((ZERO_REG != 0) && (a == '0));
  endfunction

  assign write_ok = bus.reg_write && !addr_dead(bus.write_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= (INIT_INDEX != 0 && !(ZERO_REG != 0 && i == 0)) ? DATA_W'(i) : '0;
      end
    end else if (write_ok) begin
      mem_q[bus.write_addr] <= bus.write_data;
    end
  end

  // Write-first bypass: a read of the register being written sees the new value this cycle.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (!addr_dead(bus.read_addr1)) begin
      if (bus.reg_write && bus.write_addr == bus.read_addr1) begin
        op1 = bus.write_data;
      end else begin
        op1 = mem_q[bus.read_addr1];
      end
    end
    if (!addr_dead(bus.read_addr2)) begin
      if (bus.reg_write && bus.write_addr == bus.read_addr2) begin
        op2 = bus.write_data;
      end else begin
        op2 = mem_q[bus.read_addr2];
      end
    end
  end

  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (!bus.stall) begin
      case (read_mode(bus.mem_write, bus.one_operand))
        MODE_SWAP: begin
          rd1_d = op2;
          rd2_d = op1;
        end
        MODE_ONE_OP: begin
          rd1_d = op1;
          rd2_d = op1;
        end
        default: begin
          rd1_d = op1;
          rd2_d = op2;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign bus.read_data1 = rd1_q;
  assign bus.read_data2 = rd2_q;

  // Fed from the pre-edge operand 2, so slice 0 lags read_data2 by one update.
  reg_file_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_op2_line (
    .clk    (clk),
    .reset  (reset),
    .en     (!bus.stall),
    .clr    (bus.flush),
    .d      (rd2_q),
    .q_flat (bus.read_data2_buf)
  );

endmodule

// File: tb/tb_reg_file_multimode.sv
// tb/tb_reg_file_multimode.sv - self-checking bench: two configurations against a behavioural model
module tb_reg_file_multimode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall, flush, one_op, mem_wr, reg_wr;
  logic [2:0]  ra1, ra2, wa;
  logic [15:0] wd;
  logic        check_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  reg_file_multimode_if #(.DATA_W(16), .ADDR_W(3), .BUF_DEPTH(2)) if_a ();
  reg_file_multimode_if #(.DATA_W(16), .ADDR_W(3), .BUF_DEPTH(3)) if_b ();

  assign if_a.stall = stall;        assign if_b.stall = stall;
  assign if_a.flush = flush;        assign if_b.flush = flush;
  assign if_a.one_operand = one_op; assign if_b.one_operand = one_op;
  assign if_a.mem_write = mem_wr;   assign if_b.mem_write = mem_wr;
  assign if_a.read_addr1 = ra1;     assign if_b.read_addr1 = ra1;
  assign if_a.read_addr2 = ra2;     assign if_b.read_addr2 = ra2;
  assign if_a.reg_write = reg_wr;   assign if_b.reg_write = reg_wr;
  assign if_a.write_addr = wa;      assign if_b.write_addr = wa;
  assign if_a.write_data = wd;      assign if_b.write_data = wd;

  reg_file_multimode #(.DATA_W(16), .NUM_REGS(8), .BUF_DEPTH(2), .ZERO_REG(0), .INIT_INDEX(1))
    dut_a (.clk(clk), .reset(rst_n), .bus(if_a.slave));
  reg_file_multimode #(.DATA_W(16), .NUM_REGS(6), .BUF_DEPTH(3), .ZERO_REG(1), .INIT_INDEX(0))
    dut_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));

  // Model: index 0 = 8 regs/depth 2/no zero reg/index init; index 1 = 6 regs/depth 3/zero reg/zero init
  function automatic int nregs(int m);  return (m == 0) ? 8 : 6; endfunction
  function automatic int depth(int m);  return (m == 0) ? 2 : 3; endfunction
  function automatic bit zreg(int m);   return m != 0;           endfunction
  function automatic bit initidx(int m); return m == 0;          endfunction

  logic [15:0] m_mem [2][8];
  logic [15:0] m_rd1 [2];
  logic [15:0] m_rd2 [2];
  logic [15:0] m_buf [2][3];

  function automatic logic [15:0] mrd(int m, logic [2:0] a);
    if (int'(a) >= nregs(m) || (zreg(m) && a == 3'd0)) return 16'h0;
    if (reg_wr && wa == a) return wd;
    return m_mem[m][a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 8; i++) m_mem[m][i] <= initidx(m) ? 16'(i) : 16'h0;
        m_rd1[m] <= 16'h0;
        m_rd2[m] <= 16'h0;
        for (int k = 0; k < 3; k++) m_buf[m][k] <= 16'h0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (!stall) begin
          if (mem_wr) begin
            m_rd1[m] <= mrd(m, ra2);
            m_rd2[m] <= mrd(m, ra1);
          end else if (one_op) begin
            m_rd1[m] <= mrd(m, ra1);
            m_rd2[m] <= mrd(m, ra1);
          end else begin
            m_rd1[m] <= mrd(m, ra1);
            m_rd2[m] <= mrd(m, ra2);
          end
        end
        if (flush) begin
          for (int k = 0; k < 3; k++) m_buf[m][k] <= 16'h0;
        end else if (!stall) begin
          m_buf[m][0] <= m_rd2[m];
          for (int k = 1; k < 3; k++) m_buf[m][k] <= m_buf[m][k-1];
        end
        if (reg_wr && int'(wa) < nregs(m) && !(zreg(m) && wa == 3'd0)) m_mem[m][wa] <= wd;
      end
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("a_rd1", 48'(if_a.read_data1), 48'(m_rd1[0]));
      chk("a_rd2", 48'(if_a.read_data2), 48'(m_rd2[0]));
      chk("a_buf", 48'(if_a.read_data2_buf), 48'({m_buf[0][1], m_buf[0][0]}));
      chk("b_rd1", 48'(if_b.read_data1), 48'(m_rd1[1]));
      chk("b_rd2", 48'(if_b.read_data2), 48'(m_rd2[1]));
      chk("b_buf", 48'(if_b.read_data2_buf), {m_buf[1][2], m_buf[1][1], m_buf[1][0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; one_op = 0; mem_wr = 0; reg_wr = 0;
    ra1 = 0; ra2 = 0; wa = 0; wd = 0;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_rd1", 48'(if_a.read_data1), 48'h0);
    chk("reset_a_buf", 48'(if_a.read_data2_buf), 48'h0);
    rst_n = 1'b1;
    check_en = 1'b1;

    for (int a = 0; a < 8; a++) begin
      ra1 = 3'(a);
      ra2 = 3'(7 - a);
      step();
      chk("init_rd1", 48'(if_a.read_data1), 48'(a));
      chk("init_rd2", 48'(if_a.read_data2), 48'(7 - a));
    end

    rst_n = 1'b0;
    #1;
    chk("async_a_rd1", 48'(if_a.read_data1), 48'h0);
    chk("async_a_rd2", 48'(if_a.read_data2), 48'h0);
    chk("async_a_buf", 48'(if_a.read_data2_buf), 48'h0);
    chk("async_b_buf", 48'(if_b.read_data2_buf), 48'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    reg_wr = 1; wa = 3; wd = 16'hBEEF; ra1 = 3; ra2 = 0;
    step();
    chk("bypass_rd1", 48'(if_a.read_data1), 48'hBEEF);
    reg_wr = 0;
    step();
    chk("stored_rd1", 48'(if_a.read_data1), 48'hBEEF);

    reg_wr = 1; wa = 1; wd = 16'h1111;
    step();
    wa = 2; wd = 16'h2222;
    step();
    reg_wr = 0; mem_wr = 1; ra1 = 1; ra2 = 2;
    step();
    chk("swap_rd1", 48'(if_a.read_data1), 48'h2222);
    chk("swap_rd2", 48'(if_a.read_data2), 48'h1111);
    one_op = 1;
    step();
    chk("swap_prio_rd1", 48'(if_a.read_data1), 48'h2222);
    chk("swap_prio_rd2", 48'(if_a.read_data2), 48'h1111);

    mem_wr = 0; ra1 = 5;
    step();
    chk("oneop_rd1", 48'(if_a.read_data1), 48'h5);
    chk("oneop_rd2", 48'(if_a.read_data2), 48'h5);
    one_op = 0; ra1 = 4;
    ra2 = 3; step();
    ra2 = 1; step();
    ra2 = 2; step();
    chk("stream_rd2", 48'(if_a.read_data2), 48'h2222);
    chk("stream_buf", 48'(if_a.read_data2_buf), 48'hBEEF_1111);

    stall = 1; ra1 = 1; ra2 = 5; reg_wr = 1; wa = 6; wd = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rd1", 48'(if_a.read_data1), 48'h4);
      chk("stall_rd2", 48'(if_a.read_data2), 48'h2222);
      chk("stall_buf", 48'(if_a.read_data2_buf), 48'hBEEF_1111);
    end
    reg_wr = 0; flush = 1;
    step();
    chk("flush_buf", 48'(if_a.read_data2_buf), 48'h0);
    chk("flush_rd2", 48'(if_a.read_data2), 48'h2222);
    stall = 0; flush = 0; ra1 = 6;
    step();
    chk("stall_write", 48'(if_a.read_data1), 48'h6666);

    idle();
    reg_wr = 1; wa = 0; wd = 16'hFFFF;
    step();
    wa = 7; wd = 16'h7777;
    step();
    reg_wr = 0; ra1 = 0; ra2 = 7;
    step();
    chk("b_zero_r0", 48'(if_b.read_data1), 48'h0);
    chk("b_oor_r7", 48'(if_b.read_data2), 48'h0);
    chk("a_r0", 48'(if_a.read_data1), 48'hFFFF);
    chk("a_r7", 48'(if_a.read_data2), 48'h7777);
    reg_wr = 1; wa = 5; wd = 16'h5A5A; ra1 = 5;
    step();
    chk("b_bypass_r5", 48'(if_b.read_data1), 48'h5A5A);

    for (int n = 0; n < 600; n++) begin
      stall  = ($urandom_range(3) == 0);
      flush  = ($urandom_range(7) == 0);
      one_op = $urandom_range(1);
      mem_wr = ($urandom_range(3) == 0);
      reg_wr = $urandom_range(1);
      ra1    = 3'($urandom_range(7));
      ra2    = 3'($urandom_range(7));
      wa     = ($urandom_range(2) == 0) ? ra1 : 3'($urandom_range(7));
      wd     = 16'($urandom);
      step();
    end
    idle();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
